// File: rtl/graph_bfs_engine.sv
// graph_bfs_engine: breadth-first shortest-path search over a
// stored directed adjacency matrix, streaming the path end-first.
//
// Ports:
//   CLK, RST_n      clock, synchronous active-low reset
//   adj_we/row/data adjacency row write (accepted only when idle)
//   block_mask      nodes excluded from the search, captured at start
//   start           search request with start_node / end_node
//   busy            high in every state except idle
//   done / fail     one-cycle completion pulses
//   path_len        hop count of the found path
//   path_valid/node/last, path_ready
//                   path beat stream, end_node first, start_node last

module graph_bfs_engine #(
   parameter int NODE_N    = 65,
   parameter int NODE_W    = 7,
   parameter int MAX_LEVEL = 10,
   parameter int LVL_W     = 4
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              adj_we,
   input  logic [NODE_W-1:0] adj_row,
   input  logic [NODE_N-1:0] adj_data,
   input  logic [NODE_N-1:0] block_mask,
   input  logic              start,
   input  logic [NODE_W-1:0] start_node,
   input  logic [NODE_W-1:0] end_node,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [LVL_W-1:0]  path_len,
   output logic              path_valid,
   output logic [NODE_W-1:0] path_node,
   output logic              path_last,
   input  logic              path_ready
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_FWD,
      ST_BWD,
      ST_DONE,
      ST_FAIL
   } state_t;

   localparam logic [NODE_W:0]  LP_N    = (NODE_W+1)'(NODE_N);
   localparam logic [LVL_W-1:0] LP_MAXL = LVL_W'(MAX_LEVEL);

   state_t            r_state;
   logic [NODE_N-1:0] r_adj     [NODE_N];
   logic [NODE_N-1:0] r_lvl_mem [MAX_LEVEL+1];
   logic [NODE_N-1:0] r_block;
   logic [NODE_N-1:0] r_visited;
   logic [NODE_N-1:0] r_frontier;
   logic [NODE_W-1:0] r_src;
   logic [NODE_W-1:0] r_dst;
   logic [NODE_W-1:0] r_cur;
   logic [LVL_W-1:0]  r_level;
   logic [LVL_W-1:0]  r_path_len;
   logic              r_done;
   logic              r_fail;
   logic              r_path_valid;
   logic              r_path_last;

   logic              w_row_ok;
   logic              w_nodes_ok;
   logic              w_hs;
   logic [NODE_N-1:0] w_src_oh;
   logic [NODE_N-1:0] w_reach;
   logic [NODE_N-1:0] w_next;
   logic [NODE_N-1:0] w_prev_lvl;
   logic [NODE_N-1:0] w_cand;
   logic [NODE_W-1:0] w_pred;
   logic [LVL_W-1:0]  w_lvl_m1;
   logic [LVL_W-1:0]  w_lvl_p1;

   assign w_row_ok   = ({1'b0, adj_row} < LP_N);
   assign w_nodes_ok = ({1'b0, start_node} < LP_N) &&
                       ({1'b0, end_node} < LP_N);
   assign w_hs       = r_path_valid & path_ready;
   assign w_src_oh   = NODE_N'(1) << r_src;
   assign w_lvl_m1   = r_level - 1'b1;
   assign w_lvl_p1   = r_level + 1'b1;
   assign w_next     = w_reach & ~r_visited & ~r_block;

   // Union of successor rows of every frontier node
   always_comb begin
      w_reach = '0;
      for (int i = 0; i < NODE_N; i++) begin
         if (r_frontier[i]) w_reach = w_reach | r_adj[i];
      end
   end

   // Nodes discovered one level closer to the source
   always_comb begin
      w_prev_lvl = '0;
      for (int k = 0; k <= MAX_LEVEL; k++) begin
         if (LVL_W'(k) == w_lvl_m1) w_prev_lvl = r_lvl_mem[k];
      end
   end

   // Predecessor candidates of cur; the lowest index wins
   always_comb begin
      w_cand = '0;
      for (int p = 0; p < NODE_N; p++) begin
         w_cand[p] = w_prev_lvl[p] & r_adj[p][r_cur];
      end
   end

   always_comb begin
      w_pred = '0;
      for (int p = NODE_N - 1; p >= 0; p--) begin
         if (w_cand[p]) w_pred = NODE_W'(p);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         r_state      <= ST_IDLE;
         r_block      <= '0;
         r_visited    <= '0;
         r_frontier   <= '0;
         r_src        <= '0;
         r_dst        <= '0;
         r_cur        <= '0;
         r_level      <= '0;
         r_path_len   <= '0;
         r_done       <= 1'b0;
         r_fail       <= 1'b0;
         r_path_valid <= 1'b0;
         r_path_last  <= 1'b0;
         for (int i = 0; i < NODE_N; i++) r_adj[i] <= '0;
         for (int k = 0; k <= MAX_LEVEL; k++) r_lvl_mem[k] <= '0;
      end else begin
         r_done <= 1'b0;
         r_fail <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (adj_we && w_row_ok) r_adj[adj_row] <= adj_data;
               if (start) begin
                  r_src      <= start_node;
                  r_dst      <= end_node;
                  // the source is never excluded from the search
                  r_block    <= block_mask & ~(NODE_N'(1) << start_node);
                  r_path_len <= '0;
                  if (w_nodes_ok) begin
                     r_state <= ST_INIT;
                  end else begin
                     r_state <= ST_FAIL;
                     r_fail  <= 1'b1;
                  end
               end
            end
            ST_INIT: begin
               r_visited    <= w_src_oh;
               r_frontier   <= w_src_oh;
               r_lvl_mem[0] <= w_src_oh;
               r_level      <= '0;
               r_state      <= ST_FWD;
            end
            ST_FWD: begin
               if (r_frontier[r_dst]) begin
                  r_path_len   <= r_level;
                  r_cur        <= r_dst;
                  r_path_valid <= 1'b1;
                  r_path_last  <= (r_level == '0);
                  r_state      <= ST_BWD;
               end else if (w_next == '0 || r_level == LP_MAXL) begin
                  r_state <= ST_FAIL;
                  r_fail  <= 1'b1;
               end else begin
                  r_level    <= w_lvl_p1;
                  r_visited  <= r_visited | w_next;
                  r_frontier <= w_next;
                  for (int k = 0; k <= MAX_LEVEL; k++) begin
                     if (LVL_W'(k) == w_lvl_p1) r_lvl_mem[k] <= w_next;
                  end
               end
            end
            ST_BWD: begin
               if (w_hs) begin
                  if (r_path_last) begin
                     r_path_valid <= 1'b0;
                     r_path_last  <= 1'b0;
                     r_done       <= 1'b1;
                     r_state      <= ST_DONE;
                  end else begin
                     r_cur       <= w_pred;
                     r_level     <= w_lvl_m1;
                     r_path_last <= (w_lvl_m1 == '0);
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            ST_FAIL: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy       = (r_state != ST_IDLE);
   assign done       = r_done;
   assign fail       = r_fail;
   assign path_len   = r_path_len;
   assign path_valid = r_path_valid;
   assign path_node  = r_cur;
   assign path_last  = r_path_last;

endmodule

// File: doc/graph_bfs_engine.md
GRAPH_BFS_ENGINE -- requirements
Module: graph_bfs_engine

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NODE_N, 65, node count.
- NODE_W, 7, node index width; 2^NODE_W >= NODE_N.
- MAX_LEVEL, 10, maximum hop count searched.
- LVL_W, 4, level counter width; 2^LVL_W > MAX_LEVEL.

REQ-002 Ports (name, direction, width, meaning), one per line:
- CLK, in, 1, single clock; all logic on rising edge.
- RST_n, in, 1, reset: synchronous, active-low.
- adj_we, in, 1, adjacency row write strobe.
- adj_row, in, NODE_W, row index to write.
- adj_data, in, NODE_N, successor bitmask; bit j set = directed edge row->j.
- block_mask, in, NODE_N, blocked nodes, sampled at start.
- start, in, 1, search request pulse.
- start_node, in, NODE_W, source node.
- end_node, in, NODE_W, target node.
- busy, out, 1, search or path output in progress.
- done, out, 1, one-cycle pulse after last path beat accepted.
- fail, out, 1, one-cycle pulse when no path exists within MAX_LEVEL.
- path_len, out, LVL_W, hop count of found path; valid from BACKWARD entry until next start.
- path_valid, out, 1, path node available.
- path_node, out, NODE_W, path node, emitted end_node first, start_node last.
- path_last, out, 1, marks the start_node beat.
- path_ready, in, 1, consumer accepts beat when path_valid & path_ready.

Function
REQ-003 States: IDLE, INIT, FORWARD, BACKWARD, DONE, FAIL. busy = 1 in every state except IDLE.
REQ-004 Adjacency store: NODE_N x NODE_N bits. Row adj_row <= adj_data when adj_we=1 in IDLE. Writes outside IDLE, and writes with adj_row >= NODE_N, are ignored.
REQ-005 IDLE -> INIT on start=1. start is ignored outside IDLE. start with start_node or end_node >= NODE_N -> FAIL.
REQ-006 INIT (1 cycle) actions:
- Latch block_mask, start_node, end_node.
- visited = frontier = level_mem[0] = one-hot(start_node); level = 0.
- The start node is never treated as blocked.
REQ-007 FORWARD, one cycle per level:
- next = (OR of adj rows of frontier nodes) & ~visited & ~block.
- If the end node is in frontier: path_len = level, go to BACKWARD.
- Else if next == 0 or level == MAX_LEVEL: go to FAIL.
- Else: level++, level_mem[level] = next, visited |= next, frontier = next.
REQ-008 start_node == end_node: FORWARD detects it in the first cycle; path_len = 0; single beat with path_last=1.
REQ-009 BACKWARD:
- cur = end_node; path_valid = 1, path_node = cur.
- On handshake, when level > 0: cur = lowest-index p with p in level_mem[level-1] and adj[p][cur] = 1; level--.
- On handshake, when path_last = 1: go to DONE.
REQ-010 path_last = 1 exactly when the presented beat is start_node (level == 0).
REQ-011 path_node, path_valid and path_last hold stable while path_valid & ~path_ready.
REQ-012 Beat count = path_len + 1. At most one beat per cycle; full rate when path_ready is held high.
REQ-013 DONE: done = 1 for one cycle, then IDLE. FAIL: fail = 1 for one cycle, path_valid = 0, then IDLE.
REQ-014 Latency: start to FORWARD = 2 cycles; FORWARD lasts path_len + 1 cycles.

Reset
REQ-015 RST_n = 0 at a clock edge, including mid-search or mid-path, does all of the following:
- state = IDLE.
- busy, done, fail, path_valid, path_last = 0.
- path_node, path_len, level = 0.
- visited, frontier, level_mem cleared.
- adjacency store cleared to 0.
REQ-016 No output depends on pre-reset history after the first clock with RST_n = 1.

Verification
REQ-017 Bench instance: NODE_N=8, NODE_W=3, MAX_LEVEL=4, LVL_W=3.
- Chain 0->1->2->3; start 0->3, path_ready=1 -> path_len=3, beats 3,2,1,0, path_last on 0, done one cycle later.
- Diamond 0->1, 0->2, 1->3, 2->3; start 0->3 -> beats 3,1,0 (lowest-index predecessor), path_len=2.
- Diamond with block_mask=8'b0000_0010 -> beats 3,2,0. With block_mask=8'b0000_0110 -> fail pulse, no path_valid.
- Chain 0->1->...->5, start 0->5 (5 hops > MAX_LEVEL=4) -> fail after 5 FORWARD cycles. Start 2->2 -> single beat 2 with path_last, path_len=0.
- path_ready toggled 1,0,0,1 during the chain case -> beats held stable, no loss or duplication. adj_we while busy -> adjacency unchanged.
- RST_n low during FORWARD and again during BACKWARD -> next cycle: state IDLE, all outputs 0. A subsequent search with no adjacency reloaded -> fail.
